// File: rtl/fx2_stream_writer.sv
// Drains a 32-bit first-word-fall-through FIFO into the FX2 16-bit slave FIFO, low half first.
// Optional partial-packet flush on idle timeout is enabled with `define FX2_PKTEND_EN.
module fx2_stream_writer #(
  parameter int PKT_WORDS = 256,
  parameter int TIMEOUT   = 4096
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic        FIFO_EMPTY_IN,
  input  logic [31:0] FIFO_DATA,
  output logic        FIFO_READ_NEXT_OUT,
  input  logic        USB_STREAM_FULL_N,
  input  logic        USB_STREAM_FX2RDY,
  output logic        USB_STREAM_SLWR_N,
  output logic [15:0] USB_STREAM_DATA,
  output logic        USB_STREAM_PKTEND_N,
  output logic [31:0] WORD_CNT,
  output logic        BUSY
);

  localparam int PW = $clog2(PKT_WORDS);
  localparam logic [PW-1:0] PKT_ZERO = PW'(0);
  localparam logic [PW-1:0] PKT_ONE  = PW'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [31:0]   hold_r;
  logic [PW-1:0] pkt_cnt_r;
  logic [PW-1:0] pkt_cnt_nxt_s;
  logic          slwr_n_r;
  logic [15:0]   data_r;
  logic          pktend_n_r;
  logic [31:0]   word_cnt_r;
  logic          busy_r;

  logic          go_s;
  logic          rd_s;
  logic          wr_s;
  logic [15:0]   wr_data_s;
  logic          word_done_s;
  logic          flush_s;

  assign go_s = USB_STREAM_FULL_N & USB_STREAM_FX2RDY;
  // A word is only taken when the FX2 is ready, so nothing is consumed while it is offline.
  assign rd_s = (state_r == ST_IDLE) & ~FIFO_EMPTY_IN & USB_STREAM_FX2RDY & BUS_RST_N;

  assign FIFO_READ_NEXT_OUT  = rd_s;
  assign USB_STREAM_SLWR_N   = slwr_n_r;
  assign USB_STREAM_DATA     = data_r;
  assign USB_STREAM_PKTEND_N = pktend_n_r;
  assign WORD_CNT            = word_cnt_r;
  assign BUSY                = busy_r;

  // Next-state and write-half selection.
  always_comb begin
    state_nxt_s = state_r;
    wr_s        = 1'b0;
    wr_data_s   = 16'h0000;
    word_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_s) begin
          state_nxt_s = ST_LOW;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (go_s) begin
          wr_s        = 1'b1;
          wr_data_s   = hold_r[15:0];
          state_nxt_s = ST_HIGH;
        end else begin
          state_nxt_s = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (go_s) begin
          wr_s        = 1'b1;
          wr_data_s   = hold_r[31:16];
          word_done_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HIGH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Packet fill level; a full packet wraps to zero because the FX2 commits it on its own.
  always_comb begin
    if (flush_s) begin
      pkt_cnt_nxt_s = PKT_ZERO;
    end else if (wr_s) begin
      pkt_cnt_nxt_s = pkt_cnt_r + PKT_ONE;
    end else begin
      pkt_cnt_nxt_s = pkt_cnt_r;
    end
  end

`ifdef FX2_PKTEND_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ZERO = TW'(0);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  logic [TW-1:0] timer_r;
  logic          idle_s;
  logic          expire_s;

  // Idle requires an empty FIFO, so a word arriving on the expiry cycle always beats the flush.
  assign idle_s   = (state_r == ST_IDLE) & FIFO_EMPTY_IN & (pkt_cnt_r != PKT_ZERO);
  assign expire_s = idle_s & (timer_r == TMR_LAST);
  assign flush_s  = expire_s & go_s;

  // Idle timer; saturates at expiry until the FX2 can take the packet-end strobe.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      timer_r <= TMR_ZERO;
    end else if (wr_s | rd_s | flush_s) begin
      timer_r <= TMR_ZERO;
    end else if (idle_s & ~expire_s) begin
      timer_r <= timer_r + TMR_ONE;
    end else begin
      timer_r <= timer_r;
    end
  end
`else
  logic unused_timeout_s;

  assign unused_timeout_s = (TIMEOUT > 32'sd1);
  assign flush_s          = 1'b0;
`endif

  // State, holding register and registered FX2-side outputs.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_r    <= ST_IDLE;
      hold_r     <= 32'h0000_0000;
      pkt_cnt_r  <= PKT_ZERO;
      slwr_n_r   <= 1'b1;
      data_r     <= 16'h0000;
      pktend_n_r <= 1'b1;
      word_cnt_r <= 32'h0000_0000;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pkt_cnt_r  <= pkt_cnt_nxt_s;
      slwr_n_r   <= ~wr_s;
      pktend_n_r <= ~flush_s;
      busy_r     <= (state_nxt_s != ST_IDLE) | (pkt_cnt_nxt_s != PKT_ZERO);
      if (rd_s) begin
        hold_r <= FIFO_DATA;
      end else begin
        hold_r <= hold_r;
      end
      if (wr_s) begin
        data_r <= wr_data_s;
      end else begin
        data_r <= data_r;
      end
      if (word_done_s) begin
        word_cnt_r <= word_cnt_r + 32'd1;
      end else begin
        word_cnt_r <= word_cnt_r;
      end
    end
  end

endmodule
